// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// one-byte holding register with acknowledge, overrun and framing-error flags.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  input  logic       data_ack,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_BIT = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t      state;
  logic [15:0] timer;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        rx_m, rx_s;
  logic        deliver;

  assign deliver = (state == STOP) && (timer == BIT_END) && rx_s;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_m          <= 1'b1;
      rx_s          <= 1'b1;
      state         <= IDLE;
      timer         <= '0;
      idx           <= '0;
      shreg         <= '0;
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_m          <= RxD;
      rx_s          <= rx_m;
      framing_error <= 1'b0;

      case (state)
        IDLE: begin
          timer <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (timer == HALF_BIT) begin
            timer <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        DATA: begin
          if (timer == BIT_END) begin
            timer      <= '0;
            shreg[idx] <= rx_s;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        STOP: begin
          if (timer == BIT_END) begin
            timer <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= WAIT_HIGH;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        WAIT_HIGH: begin
          timer <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          timer <= '0;
          state <= IDLE;
        end
      endcase

      // Holding register: an ack in the delivery cycle frees the slot for the new byte
      if (deliver) begin
        if (!data_valid || data_ack) begin
          data       <= shreg;
          data_valid <= 1'b1;
          if (data_ack) overrun <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_ack && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit.
module tb_uart_receiver;

  localparam int CPB = 16;
  // start edge driven after posedge P0 -> stop sample on P(2 sync + 1 + 8 + 16*9)
  localparam int DELIVER_LAT = 155;

  logic       clk = 1'b0;
  logic       reset, RxD, data_ack;
  logic [7:0] data;
  logic       data_valid, framing_error, overrun, busy;

  int n_chk = 0, n_err = 0;
  int cyc = 0, dv_rise = -1, fe_cnt = 0, busy_cnt = 0;
  logic dv_q = 1'b0;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .RxD(RxD), .data_ack(data_ack),
    .data(data), .data_valid(data_valid), .framing_error(framing_error),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    dv_q <= data_valid;
    if (data_valid && !dv_q) dv_rise <= cyc;
    if (framing_error) fe_cnt <= fe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives one frame cycle by cycle; optional ack in the delivery cycle and
  // optional reset assertion at a given cycle of the frame (aborts the frame).
  task automatic send(input logic [7:0] b, input logic stop, input bit ack_dlv,
                      input int abort_at, output int t0);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    t0 = cyc;
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c == abort_at) begin
        reset = 1'b0;
        RxD   = 1'b1;
        return;
      end
      RxD      = fr[c / CPB];
      data_ack = ack_dlv && (c == DELIVER_LAT - 1);
      tick(1);
    end
    data_ack = 1'b0;
  endtask

  task automatic ack();
    data_ack = 1'b1;
    tick(1);
    data_ack = 1'b0;
    tick(1);
  endtask

  int t0, fe0, b0;

  initial begin
    reset = 1'b0; RxD = 1'b1; data_ack = 1'b0;
    tick(4);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", data_valid, 0);
    chk("rst_ferr", framing_error, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    tick(4);

    // single byte, no ack
    fe0 = fe_cnt;
    send(8'h55, 1'b1, 1'b0, -1, t0);
    tick(4);
    chk("b55_data", data, 8'h55);
    chk("b55_valid", data_valid, 1);
    chk("b55_latency", dv_rise, t0 + DELIVER_LAT);
    chk("b55_ferr", fe_cnt - fe0, 0);
    chk("b55_ovr", overrun, 0);
    ack();
    chk("b55_ack_valid", data_valid, 0);
    chk("b55_ack_data", data, 8'h55);
    ack();
    chk("ack_idle_valid", data_valid, 0);

    // 4-cycle glitch on the line
    b0 = busy_cnt; fe0 = fe_cnt;
    RxD = 1'b0; tick(4);
    RxD = 1'b1; tick(30);
    chk("glitch_busy_len", (busy_cnt - b0 >= 1) && (busy_cnt - b0 <= 8), 1);
    chk("glitch_busy", busy, 0);
    chk("glitch_valid", data_valid, 0);
    chk("glitch_ferr", fe_cnt - fe0, 0);
    chk("glitch_ovr", overrun, 0);

    // bad stop bit followed by a break
    fe0 = fe_cnt;
    send(8'hA3, 1'b0, 1'b0, -1, t0);
    RxD = 1'b0; tick(50);
    chk("ferr_pulses", fe_cnt - fe0, 1);
    chk("ferr_valid", data_valid, 0);
    chk("ferr_busy", busy, 1);
    RxD = 1'b1; tick(6);
    chk("ferr_busy_rel", busy, 0);
    send(8'h3C, 1'b1, 1'b0, -1, t0);
    tick(4);
    chk("b3c_data", data, 8'h3C);
    chk("b3c_valid", data_valid, 1);
    chk("b3c_latency", dv_rise, t0 + DELIVER_LAT);
    ack();

    // back-to-back, no ack -> overrun
    send(8'h11, 1'b1, 1'b0, -1, t0);
    send(8'h22, 1'b1, 1'b0, -1, t0);
    tick(4);
    chk("ovr_data", data, 8'h11);
    chk("ovr_valid", data_valid, 1);
    chk("ovr_flag", overrun, 1);
    ack();
    chk("ovr_ack_valid", data_valid, 0);
    chk("ovr_ack_flag", overrun, 0);
    chk("ovr_ack_data", data, 8'h11);

    // ack coincident with the second delivery
    send(8'h11, 1'b1, 1'b0, -1, t0);
    send(8'h22, 1'b1, 1'b1, -1, t0);
    tick(4);
    chk("ackdlv_data", data, 8'h22);
    chk("ackdlv_valid", data_valid, 1);
    chk("ackdlv_ovr", overrun, 0);
    ack();

    // reset in the middle of data bit 4
    fe0 = fe_cnt;
    send(8'hF0, 1'b1, 1'b0, 5 * CPB + 8, t0);
    tick(3);
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_valid", data_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovr", overrun, 0);
    reset = 1'b1;
    tick(20);
    send(8'h0F, 1'b1, 1'b0, -1, t0);
    tick(4);
    chk("post_rst_data", data, 8'h0F);
    chk("post_rst_valid", data_valid, 1);
    chk("post_rst_ferr", fe_cnt - fe0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 10417, meaning clk cycles per bit (100 MHz / 9600 baud); legal range 8..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port RxD, input, 1 bit: asynchronous serial line, idle high.
REQ-005 The block SHALL have port data_ack, input, 1 bit: consumer acknowledges the held byte.
REQ-006 The block SHALL have port data, output, 8 bits: last accepted byte.
REQ-007 The block SHALL have port data_valid, output, 1 bit: level; high while data holds an unacknowledged byte.
REQ-008 The block SHALL have port framing_error, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-009 The block SHALL have port overrun, output, 1 bit: sticky; a byte was dropped.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 RxD SHALL pass through a 2-flop synchronizer, both flops reset to 1; all decisions use the second flop (rx_s).
- Delay: 2 cycles.
REQ-012 The frame format SHALL be 8N1: start 0, 8 data bits LSB first, stop 1.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH, with a 16-bit bit-timer and a 3-bit bit index.
REQ-014 IDLE: when rx_s=0, the FSM SHALL go to START with timer=0.
REQ-015 START: the timer SHALL increment each cycle until it reaches (CLKS_PER_BIT-1)/2 (integer division).
- At that value, if rx_s=0: go to DATA, timer=0, index=0.
- Else (glitch): return to IDLE and report nothing.
REQ-016 DATA: when the timer reaches CLKS_PER_BIT-1, the FSM SHALL sample rx_s into shift-register bit [index] and reset the timer.
- After index 7, go to STOP; otherwise index+1.
REQ-017 STOP: when the timer reaches CLKS_PER_BIT-1, the FSM SHALL sample rx_s.
- Sample 1: deliver the byte (REQ-018) and go to IDLE.
- Sample 0: pulse framing_error for exactly one cycle on the next edge, do not deliver, go to WAIT_HIGH.
REQ-018 Delivery SHALL be registered: data and data_valid update on the edge after the stop sample.
- data_valid=0, or data_ack=1 in the same cycle: data is loaded and data_valid=1.
- data_valid=1 and data_ack=0: the new byte is dropped, data is unchanged, overrun=1.
REQ-019 data_ack=1 while data_valid=1, with no simultaneous delivery, SHALL clear data_valid and overrun on the next edge; data keeps its value.
REQ-020 data_ack while data_valid=0 SHALL have no effect.
REQ-021 WAIT_HIGH SHALL stay until rx_s=1, then go to IDLE; a held-low (break) line never starts a frame.
REQ-022 A new start bit SHALL be recognised in the first IDLE cycle after a stop bit, so back-to-back frames are received without loss.
REQ-023 The timer SHALL never wrap: it resets on every sample point and every state change.

Reset
REQ-024 While reset=0 at a clk edge, the block SHALL set:
- FSM=IDLE;
- timer=0, index=0, shift register=0;
- data=8'h00;
- data_valid=0, framing_error=0, overrun=0, busy=0;
- synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no delivery or error.
- After release, the next valid frame SHALL be received correctly.

Verification (CLKS_PER_BIT=16)
REQ-026 Send 0x55 at 16 cycles/bit, data_ack held 0 -> data=8'h55 and data_valid=1, asserted exactly 1 cycle after the stop-bit sample; framing_error=0; overrun=0.
REQ-027 RxD low for 4 cycles, then high -> FSM returns to IDLE; data_valid, framing_error and overrun stay 0; busy high for no more than 8 cycles.
REQ-028 Send 0xA3 with stop bit 0, then RxD held low for 50 cycles -> one framing_error pulse; data_valid stays 0; busy stays high until RxD returns high; a following 0x3C is then received correctly.
REQ-029 Send 0x11 then 0x22 back-to-back, no ack -> data=8'h11, data_valid=1, overrun=1. Then one data_ack -> data_valid=0, overrun=0.
REQ-030 Send 0x11, then 0x22 with data_ack pulsed in the delivery cycle of 0x22 -> data=8'h22, data_valid=1, overrun=0.
REQ-031 Assert reset during data bit 4 of 0xF0, release it, then send 0x0F -> all outputs 0 during reset; then data=8'h0F, data_valid=1, framing_error never pulses.
